// File: rtl/mem_responder_pkg.sv
// Shared widths for the mem initiator/responder interface.
package mem_responder_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned COL_W  = 8;
  localparam int unsigned RLEN_W = 5;

endpackage

// File: rtl/mem_responder_sdp_ram.sv
// Simple dual-port RAM: byte-column write port, registered read port with
// optional extra output pipeline stages.
module sdp_ram #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned NUM_COLS       = 4,
  parameter int unsigned COL_W          = 8,
  parameter int unsigned PIPELINE_DEPTH = 0
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [ADDR_W-1:0]         waddr_i,
  input  logic [NUM_COLS*COL_W-1:0] wdata_i,
  input  logic [NUM_COLS-1:0]       wbe_i,
  input  logic                      re_i,
  input  logic [ADDR_W-1:0]         raddr_i,
  output logic [NUM_COLS*COL_W-1:0] rdata_o
);

  localparam int unsigned DW    = NUM_COLS * COL_W;
  localparam int unsigned WORDS = 1 << ADDR_W;

  logic [DW-1:0] mem_q  [WORDS];
  logic [DW-1:0] pipe_q [PIPELINE_DEPTH+1];

  // Storage is intentionally not reset so contents survive a logic reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        if (wbe_i[c]) begin
          mem_q[waddr_i][c*COL_W +: COL_W] <= wdata_i[c*COL_W +: COL_W];
        end
      end
    end
    if (re_i) begin
      pipe_q[0] <= mem_q[raddr_i];
    end
  end

  for (genvar g = 1; g <= int'(PIPELINE_DEPTH); g++) begin : g_pipe
    always_ff @(posedge clk_i) begin
      pipe_q[g] <= pipe_q[g-1];
    end
  end

  assign rdata_o = pipe_q[PIPELINE_DEPTH];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: single-beat byte-masked writes through a one-entry
// write buffer, and aligned power-of-two read bursts from local RAM.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned MEM_DEPTH_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rnw,
  input  logic [RLEN_W-1:0] rlen,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   wbe,
  output logic              ack,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              write_outstanding
);

  localparam int unsigned AW = MEM_DEPTH_W;

  typedef enum logic {IDLE, BURST} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       base_q, base_d;
  logic [RLEN_W-1:0]   rlen_q, rlen_d;
  logic [RLEN_W-1:0]   cnt_q, cnt_d;
  logic                rvalid_q, rvalid_d;
  logic                wbuf_valid_q, wbuf_valid_d;
  logic [AW-1:0]       wbuf_addr_q, wbuf_addr_d;
  logic [DATA_W-1:0]   wbuf_data_q, wbuf_data_d;
  logic [BE_W-1:0]     wbuf_be_q, wbuf_be_d;

  logic [AW-1:0]       req_addr;
  logic [AW-1:0]       req_base;
  logic [AW-1:0]       rd_addr;
  logic                rd_en;
  logic                wr_en;
  logic                unused_addr_hi;

  // Upper address bits alias onto the local memory.
  assign req_addr       = addr[AW-1:0];
  assign unused_addr_hi = ^addr[ADDR_W-1:AW];
  assign req_base       = req_addr & ~AW'(rlen);

  // Accept only when idle with the write buffer drained; this keeps reads and
  // write commits from ever sharing a cycle.
  assign ack   = request & (state_q == IDLE) & ~wbuf_valid_q & ~rst;
  assign rd_en = (ack & rnw) | (state_q == BURST);
  assign wr_en = wbuf_valid_q & ~rst;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    rlen_d       = rlen_q;
    cnt_d        = cnt_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_data_d  = wbuf_data_q;
    wbuf_be_d    = wbuf_be_q;
    wbuf_valid_d = ack & ~rnw;
    rvalid_d     = rd_en;
    rd_addr      = base_q + AW'(cnt_q);

    if (ack && rnw) begin
      rd_addr = req_base;
      base_d  = req_base;
      rlen_d  = rlen;
      cnt_d   = RLEN_W'(1);
      if (rlen != '0) begin
        state_d = BURST;
      end
    end else if (ack) begin
      wbuf_addr_d = req_addr;
      wbuf_data_d = wdata;
      wbuf_be_d   = wbe;
    end else if (state_q == BURST) begin
      cnt_d = cnt_q + RLEN_W'(1);
      if (cnt_q == rlen_q) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      rlen_q       <= '0;
      cnt_q        <= '0;
      rvalid_q     <= 1'b0;
      wbuf_valid_q <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_data_q  <= '0;
      wbuf_be_q    <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      rlen_q       <= rlen_d;
      cnt_q        <= cnt_d;
      rvalid_q     <= rvalid_d;
      wbuf_valid_q <= wbuf_valid_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_data_q  <= wbuf_data_d;
      wbuf_be_q    <= wbuf_be_d;
    end
  end

  assign rvalid            = rvalid_q;
  assign write_outstanding = wbuf_valid_q;

  sdp_ram #(
    .ADDR_W         (AW),
    .NUM_COLS       (BE_W),
    .COL_W          (COL_W),
    .PIPELINE_DEPTH (0)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wbuf_addr_q),
    .wdata_i (wbuf_data_q),
    .wbe_i   (wbuf_be_q),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: writes, byte masks, bursts, back-to-back
// traffic, reset mid-burst and write throughput.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        request;
  logic [29:0] addr;
  logic        rnw;
  logic [4:0]  rlen;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        ack;
  logic        rvalid;
  logic [31:0] rdata;
  logic        write_outstanding;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.MEM_DEPTH_W(12)) dut (
    .clk               (clk),
    .rst               (rst),
    .request           (request),
    .addr              (addr),
    .rnw               (rnw),
    .rlen              (rlen),
    .wdata             (wdata),
    .wbe               (wbe),
    .ack               (ack),
    .rvalid            (rvalid),
    .rdata             (rdata),
    .write_outstanding (write_outstanding)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ack at negedge sampling points; returns cycles waited.
  task automatic wait_ack(output int n);
    n = 0;
    @(negedge clk);
    while (ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at posedge+1 from idle with an empty write buffer.
  task automatic do_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    addr = a; wdata = d; wbe = be; rnw = 1'b0; request = 1'b1;
    wait_ack(n);
    chk("wr_ack", 32'(ack), 32'd1);
    chk("wr_ack_latency", 32'(n), 32'd0);
    @(posedge clk); #1 request = 1'b0;
    @(negedge clk);
    chk("wr_outstanding_hi", 32'(write_outstanding), 32'd1);
    chk("wr_no_ack_while_buffered", 32'(ack), 32'd0);
    @(negedge clk);
    chk("wr_outstanding_lo", 32'(write_outstanding), 32'd0);
    @(posedge clk); #1;
  endtask

  // Burst read; memory is expected to hold exp0+i at beat i.
  task automatic read_burst(input logic [29:0] a, input logic [4:0] len, input logic [31:0] exp0);
    int n;
    addr = a; rlen = len; rnw = 1'b1; request = 1'b1;
    wait_ack(n);
    chk("rd_ack", 32'(ack), 32'd1);
    chk("rd_ack_latency", 32'(n), 32'd0);
    chk("rd_no_rvalid_at_ack", 32'(rvalid), 32'd0);
    @(posedge clk); #1 request = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      chk("rd_rvalid", 32'(rvalid), 32'd1);
      chk("rd_rdata", rdata, exp0 + 32'(i));
    end
    @(negedge clk);
    chk("rd_rvalid_end", 32'(rvalid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; request = 1'b1; addr = '0; rnw = 1'b0; rlen = '0;
    wdata = '0; wbe = '0;

    // Reset state: request held but never acked.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wout", 32'(write_outstanding), 32'd0);
    @(posedge clk); #1 rst = 1'b0; request = 1'b0;

    // Single write then read.
    do_write(30'h10, 32'hDEADBEEF, 4'hF);
    read_burst(30'h10, 5'd0, 32'hDEADBEEF);

    // Byte-enable merge.
    do_write(30'h20, 32'h11223344, 4'hF);
    do_write(30'h20, 32'hAABBCCDD, 4'h5);
    read_burst(30'h20, 5'd0, 32'h11BB33DD);

    // Preload 0x40..0x47 with their addresses, then an 8-beat aligned burst.
    for (int i = 0; i < 8; i++) begin
      do_write(30'(32'h40 + 32'(i)), 32'h40 + 32'(i), 4'hF);
    end
    read_burst(30'h45, 5'd7, 32'h40);

    // Upper address bits alias; 2-beat burst aligned to 0x46.
    read_burst(30'h1047, 5'd1, 32'h46);

    // Back-to-back: 4-beat read then held write request.
    addr = 30'h42; rlen = 5'd3; rnw = 1'b1; request = 1'b1;
    @(negedge clk);
    chk("b2b_rd_ack", 32'(ack), 32'd1);
    @(posedge clk); #1 addr = 30'h50; rnw = 1'b0; wdata = 32'h5555AAAA; wbe = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_rvalid", 32'(rvalid), 32'd1);
      chk("b2b_rdata", rdata, 32'h40 + 32'(i));
      chk("b2b_no_ack_in_burst", 32'(ack), 32'd0);
    end
    @(negedge clk);
    chk("b2b_last_rvalid", 32'(rvalid), 32'd1);
    chk("b2b_last_rdata", rdata, 32'h43);
    chk("b2b_wr_ack", 32'(ack), 32'd1);
    @(posedge clk); #1 request = 1'b0;
    @(negedge clk);
    chk("b2b_rvalid_end", 32'(rvalid), 32'd0);
    chk("b2b_wout", 32'(write_outstanding), 32'd1);
    @(posedge clk); #1;
    read_burst(30'h50, 5'd0, 32'h5555AAAA);

    // Reset during the third beat of an 8-beat burst.
    addr = 30'h40; rlen = 5'd7; rnw = 1'b1; request = 1'b1;
    @(negedge clk);
    chk("rstb_ack", 32'(ack), 32'd1);
    @(posedge clk); #1 request = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstb_rvalid", 32'(rvalid), 32'd1);
      chk("rstb_rdata", rdata, 32'h40 + 32'(i));
    end
    rst = 1'b1; request = 1'b1; rnw = 1'b0; addr = 30'h70; wdata = 32'h0; wbe = 4'hF;
    @(negedge clk);
    chk("rstb_rvalid_cut", 32'(rvalid), 32'd0);
    chk("rstb_ack_in_rst", 32'(ack), 32'd0);
    chk("rstb_wout_in_rst", 32'(write_outstanding), 32'd0);
    @(posedge clk); #1 rst = 1'b0; rnw = 1'b1; addr = 30'h1044; rlen = 5'd0;
    @(negedge clk);
    chk("rstb_new_ack", 32'(ack), 32'd1);
    chk("rstb_no_stale_rvalid", 32'(rvalid), 32'd0);
    @(posedge clk); #1 request = 1'b0;
    @(negedge clk);
    chk("rstb_new_rvalid", 32'(rvalid), 32'd1);
    chk("rstb_mem_retained", rdata, 32'h44);
    @(posedge clk); #1;

    // Write throughput: held request acks every other cycle.
    addr = 30'h60; rnw = 1'b0; wdata = 32'hC0FFEE00; wbe = 4'hF; request = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("thru_ack", 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("thru_wout", 32'(write_outstanding), (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1 request = 1'b0;
    read_burst(30'h60, 5'd0, 32'hC0FFEE00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH_W, default 12, giving log2 of the word count of the local memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-004 SHALL have port request, input, 1, initiator request valid; held until ack.
REQ-005 SHALL have port addr, input, 30, word address; only bits [MEM_DEPTH_W-1:0] are used, upper bits alias.
REQ-006 SHALL have port rnw, input, 1, 1 = read, 0 = write.
REQ-007 SHALL have port rlen, input, 5, read burst length minus one; rlen+1 is a power of two.
REQ-008 SHALL have port wdata, input, 32, write data.
REQ-009 SHALL have port wbe, input, 4, write byte enables.
REQ-010 SHALL have port ack, output, 1, request accepted this cycle.
REQ-011 SHALL have port rvalid, output, 1, rdata valid this cycle.
REQ-012 SHALL have port rdata, output, 32, read data.
REQ-013 SHALL have port write_outstanding, output, 1, an accepted write is not yet committed to memory.

Function
REQ-014 SHALL implement states IDLE and BURST.
REQ-015 SHALL assert ack combinationally iff request & state==IDLE & write buffer empty; ack never asserts without request.
REQ-016 On write ack, SHALL capture addr/wdata/wbe into a one-entry write buffer; commit happens the next cycle, with only the bytes enabled by wbe written.
REQ-017 write_outstanding SHALL be high exactly while the write buffer is valid, i.e. the one cycle after a write ack.
REQ-018 Burst base SHALL be addr with its low log2(rlen+1) bits cleared; word i is returned at address base+i.
REQ-019 On read ack, SHALL issue the memory read of word 0 in the same cycle and latch base, rlen and counter=1.
REQ-020 On read ack, SHALL go to BURST if rlen!=0 and stay in IDLE if rlen==0.
REQ-021 In BURST, SHALL issue word counter each cycle, increment counter, and return to IDLE in the cycle it issues word rlen.
REQ-022 rvalid SHALL be a register set in the cycle after each issue, so a burst yields rlen+1 consecutive rvalid cycles with no gaps, the first at ack+1.
REQ-023 rdata SHALL be memory output for the issued word; it is don't-care when rvalid=0.
REQ-024 SHALL allow a new request to be acked in IDLE while the final rvalid of a prior burst is still pending (pipelined).
REQ-025 Reads and write commits SHALL never overlap in the same cycle, because ack requires an empty write buffer.
REQ-026 A read following a write to the same address SHALL return the new data.
REQ-027 Address arithmetic SHALL be modulo 2^MEM_DEPTH_W.

Reset
REQ-028 On rst, SHALL force state=IDLE, rvalid=0, write buffer invalid (ack=0 that cycle, write_outstanding=0), and counter=0.
REQ-029 Reset mid-burst SHALL abort the burst with no further rvalid; a pending uncommitted write is discarded; memory contents are retained.

Structure
REQ-030 The state enum SHALL be local; no new shared-package typedefs; the rlen width (5) is taken from the shared mem interface definition.
REQ-031 SHALL instantiate sdp_ram, with 4 byte columns of width 8, PIPELINE_DEPTH 0, write port for commits and read port for bursts.

Verification
REQ-032 Single write then read: write addr 0x10, wdata 0xDEADBEEF, wbe 0xF. Response: ack in same cycle, write_outstanding=1 for one cycle. Then read addr 0x10, rlen 0. Response: one rvalid at ack+1, rdata 0xDEADBEEF.
REQ-033 Byte-enable write: write 0x11223344 then 0xAABBCCDD with wbe 0x5. Response: subsequent read returns 0x11BB33DD.
REQ-034 Aligned burst: memory words 0x40..0x47 preloaded with their addresses; read addr 0x45, rlen 7. Response: 8 consecutive rvalids returning 0x40..0x47 in order, state back to IDLE.
REQ-035 Back-to-back traffic: read rlen 3 immediately followed by a held write request. Response: write ack in the cycle after the last issue, not during BURST; no rvalid gap.
REQ-036 Reset mid-burst: assert rst during the third beat of an rlen 7 burst. Response: rvalid=0 from the next cycle, ack=0 and write_outstanding=0 during reset, and a new request is accepted after reset.
REQ-037 Write throughput: request held high with continuous writes. Response: acks on alternating cycles; write_outstanding alternates 0/1.
